voice_allocator: RTL and testbench
==================================

VOICE_ALLOCATOR -- requirements
Module: voice_allocator

Interface
REQ-001 Parameter NUM_VOICES, default 4, number of voice slots managed; a power of two, 2..8.
REQ-002 Parameter RETRIG_CYCLES, default 16, cycles a re-used voice's gate is held low before re-gating; minimum 1.
REQ-003 clk  in  1  system clock; the single clock domain.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 ev_valid  in  1  note event offered.
REQ-006 ev_ready  out  1  allocator can accept an event.
REQ-007 ev_is_on  in  1  1 = note-on, 0 = note-off.
REQ-008 ev_note  in  7  MIDI note number.
REQ-009 all_off  in  1  panic: release every voice.
REQ-010 voice_gate  out  NUM_VOICES  per-voice envelope gate.
REQ-011 voice_note  out  7*NUM_VOICES  per-voice note; voice i at bits [7i+6:7i].
REQ-012 voice_used  out  NUM_VOICES  per-voice slot holds a note.
REQ-013 last_voice  out  clog2(NUM_VOICES)  index of the most recently allocated voice.

Function
REQ-014 Transfer occurs on a cycle with ev_valid=1 and ev_ready=1; ev_is_on and ev_note are captured on that cycle only.
REQ-015 States: IDLE (ev_ready=1), ALLOC, RETRIG, APPLY; ev_ready=0 in every state except IDLE.
REQ-016 IDLE -> ALLOC on transfer (cycle T); ALLOC evaluates the captured event during T+1.
REQ-017 Note-off in ALLOC: every voice with voice_used=1 and a matching note gets gate=0 and used=0, visible at T+2; state returns to IDLE (ev_ready=1 at T+2); with no match, no output changes.
REQ-018 Note-on target priority: (1) lowest-index used voice already holding ev_note; (2) else lowest-index voice with used=0; (3) else the least-recently-allocated voice (steal).
REQ-019 Note-on to an unused voice with gate=0: gate=1, note, used=1 and last_voice are written, visible at T+2; state returns to IDLE.
REQ-020 Note-on to a voice whose gate=1 (retrigger or steal): gate=0 and new note/used=1 visible at T+2; RETRIG counts RETRIG_CYCLES cycles; APPLY sets gate=1; gate high at T+2+RETRIG_CYCLES; ev_ready=1 on the same cycle.
REQ-021 LRU: per-voice age of clog2(NUM_VOICES) bits forming a permutation of 0..NUM_VOICES-1; on each note-on allocation the target's age becomes 0 and every voice whose age was below the target's old age increments; note-off leaves ages unchanged.
REQ-022 Steal target is the voice with age NUM_VOICES-1.
REQ-023 all_off has priority over all other activity on any cycle: next cycle all gates=0, all used=0, state=IDLE, RETRIG counter cleared, any captured event discarded; ev_ready=0 during the all_off cycle; notes and ages retained.
REQ-024 ev_valid while ev_ready=0 is ignored; the source must hold it until transfer.
REQ-025 voice_note of a released voice keeps its last value (used=0 is authoritative).

Reset
REQ-026 While rst=1: voice_gate=0, voice_used=0, voice_note all 0, last_voice=0, age of voice i = i, state=IDLE, RETRIG counter=0; ev_ready=0 during reset and 1 on the first cycle after rst deasserts.
REQ-027 rst mid-RETRIG aborts the sequence: the pending gate never asserts.

Verification
REQ-028 After reset, note-on 60 at T -> voice 0: gate[0]=1, note=60, used[0]=1 at T+2; ev_ready=1 at T+2.
REQ-029 Note-ons 60,62,64,65 then 67 (RETRIG_CYCLES=4) -> 67 steals voice 0: gate[0]=0 at T+2, note[0]=67, gate[0]=1 at T+6; last_voice=0.
REQ-030 Note-on 62 while voice 1 already holds 62 gated -> voice 1 gate low T+2..T+5, high T+6; voices 0,2,3 unchanged; voice 1 becomes newest.
REQ-031 Note-off 64 with 64 on voice 2 -> gate[2]=0, used[2]=0 at T+2; next note-on 70 lands on voice 2 with no retrigger delay.
REQ-032 all_off asserted at T+3 during a steal's RETRIG -> at T+4 all gates=0, used=0, ev_ready=1; stolen voice never re-gates.
REQ-033 Note-off 50 with no voice holding 50 -> no output change; ev_ready=1 at T+2; ev_valid held while ev_ready=0 transfers exactly once.

Source files
------------

// File: rtl/voice_allocator_if.sv
// Note-event handshake between an event source and the voice allocator.
interface voice_allocator_if;
  logic       ev_valid;
  logic       ev_ready;
  logic       ev_is_on;
  logic [6:0] ev_note;

  modport master (output ev_valid, ev_is_on, ev_note, input ev_ready);
  modport slave  (input ev_valid, ev_is_on, ev_note, output ev_ready);
endinterface

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: note matching, free-slot fill, LRU stealing,
// retrigger gate gap, and an all-notes-off panic.
module voice_slot #(
  parameter int AW  = 2,
  parameter int IDX = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          all_off,
  input  logic          wr_on,
  input  logic          wr_gate,
  input  logic          rel,
  input  logic          gate_on,
  input  logic          age_upd,
  input  logic [AW-1:0] tgt_age,
  input  logic [6:0]    note_in,
  output logic          gate,
  output logic          used,
  output logic [6:0]    note,
  output logic [AW-1:0] age
);
  always_ff @(posedge clk) begin
    if (rst) begin
      gate <= 1'b0;
      used <= 1'b0;
      note <= '0;
      age  <= AW'(IDX);
    end else if (all_off) begin
      gate <= 1'b0;
      used <= 1'b0;
    end else begin
      if (wr_on) begin
        note <= note_in;
        used <= 1'b1;
        gate <= wr_gate;
      end else if (rel) begin
        gate <= 1'b0;
        used <= 1'b0;
      end else if (gate_on) begin
        gate <= 1'b1;
      end
      // Target becomes newest; only voices younger than it age by one.
      if (age_upd) begin
        if (wr_on)               age <= '0;
        else if (age < tgt_age)  age <= age + 1'b1;
      end
    end
  end
endmodule

module voice_allocator #(
  parameter int NUM_VOICES    = 4,
  parameter int RETRIG_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  voice_allocator_if.slave              ev,
  input  logic                          all_off,
  output logic [NUM_VOICES-1:0]         voice_gate,
  output logic [7*NUM_VOICES-1:0]       voice_note,
  output logic [NUM_VOICES-1:0]         voice_used,
  output logic [$clog2(NUM_VOICES)-1:0] last_voice
);
  localparam int AW = $clog2(NUM_VOICES);
  localparam int CW = $clog2(RETRIG_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ALLOC, RETRIG, APPLY} state_t;

  state_t                         state, nxt;
  logic [CW-1:0]                  cnt;
  logic                           ev_on_q;
  logic [6:0]                     ev_note_q;
  logic [AW-1:0]                  pend;

  logic [NUM_VOICES-1:0]          slot_gate, slot_used;
  logic [NUM_VOICES-1:0][6:0]     slot_note;
  logic [NUM_VOICES-1:0][AW-1:0]  slot_age;

  logic                           hit_any, free_any;
  logic [AW-1:0]                  hit_idx, free_idx, steal_idx, tgt;
  logic [NUM_VOICES-1:0]          match;
  logic [NUM_VOICES-1:0]          wr_on, rel, gate_on;
  logic                           wr_gate, age_upd, rdy, xfer;

  assign xfer = ev.ev_valid && rdy;

  // Descending scan so the lowest index wins each priority class.
  always_comb begin
    hit_any   = 1'b0;
    free_any  = 1'b0;
    hit_idx   = '0;
    free_idx  = '0;
    steal_idx = '0;
    match     = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      match[i] = slot_used[i] && (slot_note[i] == ev_note_q);
      if (match[i])     begin hit_any  = 1'b1; hit_idx  = AW'(i); end
      if (!slot_used[i]) begin free_any = 1'b1; free_idx = AW'(i); end
      if (slot_age[i] == AW'(NUM_VOICES - 1)) steal_idx = AW'(i);
    end
    tgt = hit_any ? hit_idx : (free_any ? free_idx : steal_idx);
  end

  always_ff @(posedge clk) begin
    if (rst || all_off) state <= IDLE;
    else                state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:   if (xfer) nxt = ALLOC;
      ALLOC: begin
        if (ev_on_q && slot_gate[tgt]) nxt = (RETRIG_CYCLES == 1) ? APPLY : RETRIG;
        else                           nxt = IDLE;
      end
      RETRIG: if (cnt == CW'(RETRIG_CYCLES - 2)) nxt = APPLY;
      APPLY:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    rdy     = (state == IDLE) && !rst && !all_off;
    age_upd = (state == ALLOC) && ev_on_q;
    wr_gate = !slot_gate[tgt];
    for (int i = 0; i < NUM_VOICES; i++) begin
      wr_on[i]   = age_upd && (tgt == AW'(i));
      rel[i]     = (state == ALLOC) && !ev_on_q && match[i];
      gate_on[i] = (state == APPLY) && (pend == AW'(i));
    end
  end

  assign ev.ev_ready = rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      ev_on_q    <= 1'b0;
      ev_note_q  <= '0;
      pend       <= '0;
      last_voice <= '0;
    end else if (all_off) begin
      cnt <= '0;
    end else begin
      if (xfer) begin
        ev_on_q   <= ev.ev_is_on;
        ev_note_q <= ev.ev_note;
      end
      if (age_upd) begin
        pend       <= tgt;
        last_voice <= tgt;
      end
      cnt <= (state == RETRIG) ? cnt + 1'b1 : '0;
    end
  end

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_slot
    voice_slot #(.AW(AW), .IDX(g)) u_slot (
      .clk     (clk),
      .rst     (rst),
      .all_off (all_off),
      .wr_on   (wr_on[g]),
      .wr_gate (wr_gate),
      .rel     (rel[g]),
      .gate_on (gate_on[g]),
      .age_upd (age_upd),
      .tgt_age (slot_age[tgt]),
      .note_in (ev_note_q),
      .gate    (slot_gate[g]),
      .used    (slot_used[g]),
      .note    (slot_note[g]),
      .age     (slot_age[g])
    );
  end

  assign voice_gate = slot_gate;
  assign voice_used = slot_used;
  assign voice_note = slot_note;
endmodule

// File: tb/tb_voice_allocator.sv
// Scoreboard bench for voice_allocator: a behavioural voice model predicts
// output snapshots at absolute cycles; a negedge monitor pops and compares them.
module tb_voice_allocator;
  localparam int N = 4;
  localparam int R = 4;

  typedef struct {
    int          at;
    logic [3:0]  gate;
    logic [3:0]  used;
    logic [27:0] notes;
    logic [1:0]  last;
    logic        rdy;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        all_off = 1'b0;
  logic [3:0]  voice_gate, voice_used;
  logic [27:0] voice_note;
  logic [1:0]  last_voice;

  voice_allocator_if vif ();

  voice_allocator #(.NUM_VOICES(N), .RETRIG_CYCLES(R)) dut (
    .clk        (clk),
    .rst        (rst),
    .ev         (vif.slave),
    .all_off    (all_off),
    .voice_gate (voice_gate),
    .voice_note (voice_note),
    .voice_used (voice_used),
    .last_voice (last_voice)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   n_chk = 0, n_err = 0;
  int   n_xfer = 0, n_send = 0;
  exp_t sb[$];
  exp_t e;

  bit   m_gate[N], m_used[N];
  int   m_note[N], m_age[N], m_last;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (!rst && vif.ev_valid && vif.ev_ready) n_xfer++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < N; i++) begin
      m_gate[i] = 0; m_used[i] = 0; m_note[i] = 0; m_age[i] = i;
    end
    m_last = 0;
  endfunction

  function automatic void snap(input int at, input logic rdy);
    exp_t s;
    s.at = at; s.rdy = rdy; s.last = 2'(m_last);
    for (int i = 0; i < N; i++) begin
      s.gate[i] = m_gate[i];
      s.used[i] = m_used[i];
      s.notes[7*i +: 7] = 7'(m_note[i]);
    end
    sb.push_back(s);
  endfunction

  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].at < cyc) begin
      e = sb.pop_front();
      chk("sb_missed", 32'(cyc), 32'(e.at));
    end
    while (sb.size() > 0 && sb[0].at == cyc) begin
      e = sb.pop_front();
      chk("gate",  32'(voice_gate),   32'(e.gate));
      chk("used",  32'(voice_used),   32'(e.used));
      chk("notes", 32'(voice_note),   32'(e.notes));
      chk("last",  32'(last_voice),   32'(e.last));
      chk("ready", 32'(vif.ev_ready), 32'(e.rdy));
    end
  end

  // Called at a negedge; returns at the negedge of T+1 with ev_valid dropped.
  task automatic send(input bit on, input int note, output int t);
    int tg, old;
    vif.ev_valid = 1'b1; vif.ev_is_on = on; vif.ev_note = 7'(note);
    t = -1;
    for (int k = 0; k < 60; k++) begin
      if (vif.ev_ready) begin t = cyc; break; end
      @(negedge clk);
    end
    if (t < 0) begin
      chk("xfer_timeout", 32'(vif.ev_ready), 32'd1);
      vif.ev_valid = 1'b0;
      return;
    end
    n_send++;
    if (!on) begin
      for (int i = 0; i < N; i++)
        if (m_used[i] && m_note[i] == note) begin m_gate[i] = 0; m_used[i] = 0; end
      snap(t + 2, 1'b1);
    end else begin
      tg = -1;
      for (int i = 0; i < N; i++) if (tg < 0 && m_used[i] && m_note[i] == note) tg = i;
      for (int i = 0; i < N; i++) if (tg < 0 && !m_used[i]) tg = i;
      for (int i = 0; i < N; i++) if (tg < 0 && m_age[i] == N - 1) tg = i;
      old = m_age[tg];
      for (int i = 0; i < N; i++)
        if (i == tg) m_age[i] = 0; else if (m_age[i] < old) m_age[i]++;
      m_note[tg] = note; m_used[tg] = 1; m_last = tg;
      if (m_gate[tg]) begin
        m_gate[tg] = 0;
        snap(t + 2, 1'b0);
        snap(t + 1 + R, 1'b0);
        m_gate[tg] = 1;
        snap(t + 2 + R, 1'b1);
      end else begin
        m_gate[tg] = 1;
        snap(t + 2, 1'b1);
      end
    end
    @(negedge clk);
    vif.ev_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && sb.size() > 0; k++) @(negedge clk);
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic prune_future();
    while (sb.size() > 0 && sb[$].at > cyc) void'(sb.pop_back());
  endtask

  initial begin
    int t;
    vif.ev_valid = 1'b0; vif.ev_is_on = 1'b0; vif.ev_note = '0;
    m_reset();
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(vif.ev_ready), 32'd0);
    chk("rst_gate",  32'(voice_gate),   32'd0);
    chk("rst_used",  32'(voice_used),   32'd0);
    chk("rst_notes", 32'(voice_note),   32'd0);
    chk("rst_last",  32'(last_voice),   32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(vif.ev_ready), 32'd1);

    // Fill all four voices, then a fifth note steals the oldest (voice 0).
    send(1, 60, t); drain();
    send(1, 62, t); drain();
    send(1, 64, t); drain();
    send(1, 65, t); drain();
    send(1, 67, t);
    // Re-strike 62 immediately: ev_valid held through the retrigger busy window.
    send(1, 62, t); drain();
    send(0, 64, t); drain();
    send(1, 70, t); drain();
    send(0, 50, t); drain();
    chk("xfer_once", 32'(n_xfer), 32'(n_send));

    // Panic during a steal's retrigger gap.
    send(1, 72, t);
    while (cyc < t + 3) @(negedge clk);
    prune_future();
    all_off = 1'b1;
    #1 chk("alloff_ready", 32'(vif.ev_ready), 32'd0);
    for (int i = 0; i < N; i++) begin m_gate[i] = 0; m_used[i] = 0; end
    snap(t + 4, 1'b1);
    snap(t + 6, 1'b1);
    @(posedge clk); #1 all_off = 1'b0;
    drain();

    // Reset in the middle of a retrigger must drop the pending gate.
    send(1, 60, t); drain();
    send(1, 60, t);
    while (cyc < t + 3) @(negedge clk);
    prune_future();
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_gate",  32'(voice_gate),   32'd0);
    chk("midrst_ready", 32'(vif.ev_ready), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    m_reset();
    repeat (6) @(negedge clk);
    chk("midrst_no_regate", 32'(voice_gate), 32'd0);
    chk("midrst_used",      32'(voice_used), 32'd0);
    send(1, 55, t); drain();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
    $fatal(1);
  end
endmodule
